// File: rtl/viterbi_pkg.sv
// Shared constants, state type and parity helper for the K=7, rate-1/2
// convolutional code used by the encoder and the Viterbi decoder.
package viterbi_pkg;

   localparam int unsigned K          = 7;
   localparam int unsigned NUM_STATES = 64;
   localparam logic [6:0]  G0         = 7'o171;
   localparam logic [6:0]  G1         = 7'o133;

   typedef enum logic {
      DATA = 1'b0,
      TAIL = 1'b1
   } enc_state_t;

   // window[0] is the current bit, window[i] the bit accepted i beats earlier.
   // Returns {parity(G1), parity(G0)}.
   function automatic logic [1:0] conv_out(input logic [6:0] window,
                                           input logic [6:0] g0 = G0,
                                           input logic [6:0] g1 = G1);
      return {^(window & g1), ^(window & g0)};
   endfunction

endpackage

// File: rtl/conv_encoder_k7.sv
// Rate-1/2, K=7 convolutional encoder with a one-deep registered output
// stage and optional K-1 zero tail bits per frame.
module conv_encoder_k7 #(
   parameter int unsigned K       = viterbi_pkg::K,
   parameter logic [6:0]  G0      = viterbi_pkg::G0,
   parameter logic [6:0]  G1      = viterbi_pkg::G1,
   parameter bit          TAIL_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] code_pair,
   output logic       out_last
);

   import viterbi_pkg::*;

   localparam int unsigned SRW = K - 1;
   localparam int unsigned TCW = $clog2(K - 1);

   enc_state_t       state_q, state_d;
   logic [SRW-1:0]   sr_q, sr_d;
   logic [TCW-1:0]   tail_cnt_q, tail_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       code_pair_q, code_pair_d;
   logic             out_last_q, out_last_d;
   logic             adv;

   // Output register may be (re)loaded when empty or being consumed.
   always_comb begin
      adv = !out_valid_q || out_ready;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DATA;
      end else begin
         state_q <= state_d;
      end
   end

   // Shift register, tail counter and output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q        <= '0;
         tail_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         code_pair_q <= 2'b00;
         out_last_q  <= 1'b0;
      end else begin
         sr_q        <= sr_d;
         tail_cnt_q  <= tail_cnt_d;
         out_valid_q <= out_valid_d;
         code_pair_q <= code_pair_d;
         out_last_q  <= out_last_d;
      end
   end

   // Next state and datapath: everything advances only when the output can load.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      tail_cnt_d  = tail_cnt_q;
      out_valid_d = out_valid_q;
      code_pair_d = code_pair_q;
      out_last_d  = out_last_q;
      if (adv) begin
         // Drains unless a new beat is loaded below; code_pair keeps its value.
         out_valid_d = 1'b0;
         unique case (state_q)
            DATA: begin
               if (in_valid) begin
                  out_valid_d = 1'b1;
                  code_pair_d = conv_out({sr_q, in_bit}, G0, G1);
                  out_last_d  = in_last && !TAIL_EN;
                  sr_d        = {sr_q[SRW-2:0], in_bit};
                  if (in_last) begin
                     if (TAIL_EN) begin
                        state_d    = TAIL;
                        tail_cnt_d = '0;
                     end else begin
                        sr_d = '0;
                     end
                  end
               end
            end
            TAIL: begin
               out_valid_d = 1'b1;
               code_pair_d = conv_out({sr_q, 1'b0}, G0, G1);
               out_last_d  = 1'b0;
               sr_d        = {sr_q[SRW-2:0], 1'b0};
               tail_cnt_d  = tail_cnt_q + TCW'(1);
               if (tail_cnt_q == TCW'(K - 2)) begin
                  out_last_d = 1'b1;
                  sr_d       = '0;
                  tail_cnt_d = '0;
                  state_d    = DATA;
               end
            end
            default: begin
               state_d = DATA;
            end
         endcase
      end
   end

   // Outputs: input is accepted only in DATA and only when the output can load.
   always_comb begin
      in_ready  = adv && (state_q == DATA);
      out_valid = out_valid_q;
      code_pair = code_pair_q;
      out_last  = out_last_q;
   end

endmodule

// File: tb/tb_conv_encoder_k7.sv
module tb_conv_encoder_k7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sel = 1'b0;   // 0: tail-enabled instance, 1: no-tail instance
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;

   logic       in_valid_a, in_ready_a, out_valid_a, out_last_a;
   logic       in_valid_b, in_ready_b, out_valid_b, out_last_b;
   logic [1:0] code_pair_a, code_pair_b;
   logic       obs_valid, obs_ready, obs_last;
   logic [1:0] obs_pair;

   int n_checks = 0;
   int n_fail   = 0;

   bit         frm[$];
   bit         stim_bit[$];
   bit         stim_last[$];
   logic [1:0] exp_pair[$];
   bit         exp_last[$];

   logic [6:0] g0b = 7'o171;
   logic [6:0] g1b = 7'o133;
   logic [1:0] imp_tab [7] = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11};
   logic [1:0] two_tab [8] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b10, 2'b11};

   always #5 clk = ~clk;

   assign in_valid_a = in_valid & ~sel;
   assign in_valid_b = in_valid & sel;
   assign obs_valid  = sel ? out_valid_b : out_valid_a;
   assign obs_ready  = sel ? in_ready_b  : in_ready_a;
   assign obs_last   = sel ? out_last_b  : out_last_a;
   assign obs_pair   = sel ? code_pair_b : code_pair_a;

   conv_encoder_k7 #(.TAIL_EN(1'b1)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_bit(in_bit), .in_last(in_last),
      .out_valid(out_valid_a), .out_ready(out_ready), .code_pair(code_pair_a), .out_last(out_last_a)
   );

   conv_encoder_k7 #(.TAIL_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_bit(in_bit), .in_last(in_last),
      .out_valid(out_valid_b), .out_ready(out_ready), .code_pair(code_pair_b), .out_last(out_last_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference model: each output pair is the GF(2) sum of the frame bits that
   // fall under the generator taps; bits before the frame and after it are zero.
   task automatic add_frame(input bit tail_en);
      int unsigned n;
      int unsigned tot;
      logic [1:0]  p;
      n   = frm.size();
      tot = n + (tail_en ? 6 : 0);
      for (int unsigned t = 0; t < tot; t++) begin
         p = 2'b00;
         for (int unsigned i = 0; i < 7; i++) begin
            if (t >= i && (t - i) < n) begin
               p[0] = p[0] ^ (frm[t - i] & g0b[i]);
               p[1] = p[1] ^ (frm[t - i] & g1b[i]);
            end
         end
         exp_pair.push_back(p);
         exp_last.push_back(t == tot - 1);
      end
      for (int unsigned t = 0; t < n; t++) begin
         stim_bit.push_back(frm[t]);
         stim_last.push_back(t == n - 1);
      end
      frm.delete();
   endtask

   task automatic add_impulse();
      stim_bit.push_back(1'b1);
      stim_last.push_back(1'b1);
      for (int i = 0; i < 7; i++) begin
         exp_pair.push_back(imp_tab[i]);
         exp_last.push_back(i == 6);
      end
   endtask

   // Drive queued stimulus into the selected instance and score every output beat.
   task automatic run(input bit s, input int unsigned ready_pct, input int unsigned valid_pct);
      int unsigned cyc;
      int unsigned tail_left;
      bit          hold;
      logic [1:0]  hpair;
      logic        hlast;
      logic        exp_rdy;
      cyc = 0; tail_left = 0; hold = 0; hpair = 2'b00; hlast = 1'b0;
      sel = s;
      while ((stim_bit.size() != 0 || exp_pair.size() != 0) && cyc < 4000) begin
         in_valid  = (stim_bit.size() != 0) && ($urandom_range(99) < valid_pct);
         in_bit    = in_valid ? stim_bit[0] : 1'b0;
         in_last   = in_valid ? stim_last[0] : 1'b0;
         out_ready = ($urandom_range(99) < ready_pct);
         @(negedge clk);
         if (hold) begin
            check("stall_valid", obs_valid, 1);
            check("stall_pair", obs_pair, hpair);
            check("stall_last", obs_last, hlast);
         end
         exp_rdy = (tail_left == 0) && (!obs_valid || out_ready);
         check("in_ready", obs_ready, exp_rdy);
         if (obs_valid && out_ready) begin
            if (exp_pair.size() == 0) begin
               check("extra_beat", obs_valid, 0);
            end else begin
               check("code_pair", obs_pair, exp_pair.pop_front());
               check("out_last", obs_last, exp_last.pop_front());
            end
         end
         hold  = obs_valid && !out_ready;
         hpair = obs_pair;
         hlast = obs_last;
         if (tail_left != 0) begin
            if (!obs_valid || out_ready) tail_left--;
         end else if (in_valid && obs_ready) begin
            if (stim_last[0] && !s) tail_left = 6;
            void'(stim_bit.pop_front());
            void'(stim_last.pop_front());
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("run_timeout", (cyc < 4000), 1);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("idle_after", obs_valid, 0);
      @(posedge clk); #1;
      stim_bit.delete(); stim_last.delete(); exp_pair.delete(); exp_last.delete();
   endtask

   initial begin
      #1;
      check("rst_valid_a", out_valid_a, 0);
      check("rst_pair_a", code_pair_a, 0);
      check("rst_last_a", out_last_a, 0);
      check("rst_ready_a", in_ready_a, 1);
      check("rst_valid_b", out_valid_b, 0);
      check("rst_ready_b", in_ready_b, 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Impulse, single-bit frame.
      add_impulse();
      run(1'b0, 100, 100);

      // Frame 1,1: sum of impulse and its 1-beat delayed copy.
      stim_bit.push_back(1'b1); stim_last.push_back(1'b0);
      stim_bit.push_back(1'b1); stim_last.push_back(1'b1);
      for (int i = 0; i < 8; i++) begin
         exp_pair.push_back(two_tab[i]);
         exp_last.push_back(i == 7);
      end
      run(1'b0, 100, 100);

      // Impulse again: shift register must have returned to zero.
      add_impulse();
      run(1'b0, 100, 100);

      // All-zero 16-bit frame -> 22 zero pairs.
      for (int i = 0; i < 16; i++) frm.push_back(1'b0);
      add_frame(1'b1);
      run(1'b0, 100, 100);

      // 64-bit random frame, full rate and then with 30% out_ready duty.
      for (int i = 0; i < 64; i++) frm.push_back(1'($urandom));
      for (int i = 0; i < 64; i++) frm.push_back(frm[i]);
      begin
         bit second[$];
         for (int i = 64; i < 128; i++) second.push_back(frm[i]);
         for (int i = 0; i < 64; i++) void'(frm.pop_back());
         add_frame(1'b1);
         run(1'b0, 100, 100);
         frm = second;
         add_frame(1'b1);
         run(1'b0, 30, 100);
      end

      // Back-to-back random frames with input gaps and backpressure.
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 10 + f; i++) frm.push_back(1'($urandom));
         add_frame(1'b1);
      end
      run(1'b0, 60, 70);

      // No-tail instance: frame A ends in 1, frame B starts with 1.
      for (int i = 0; i < 7; i++) frm.push_back(1'($urandom));
      frm.push_back(1'b1);
      add_frame(1'b0);
      frm.push_back(1'b1);
      for (int i = 0; i < 7; i++) frm.push_back(1'($urandom));
      add_frame(1'b0);
      begin
         logic [1:0] b_first;
         b_first = exp_pair[8];
         check("b_first_model", b_first, 2'b11);
      end
      run(1'b1, 100, 100);
      for (int i = 0; i < 20; i++) frm.push_back(1'($urandom));
      add_frame(1'b0);
      frm.push_back(1'b1);
      add_frame(1'b0);
      run(1'b1, 50, 80);

      // Reset in the middle of the tail (tail_cnt = 3).
      sel = 1'b0;
      in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("rt_in_ready", in_ready_a, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rt_async_valid", out_valid_a, 0);
      check("rt_async_pair", code_pair_a, 0);
      check("rt_async_last", out_last_a, 0);
      check("rt_async_ready", in_ready_a, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      add_impulse();
      run(1'b0, 100, 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
